// File: rtl/mux_tree_lut.sv
// mux_tree_lut: multi-lane reprogrammable lookup cell built from 2:1 mux trees.
// All lanes share one truth table, loaded serially through a shadow register.
// Optional macro MUX_TREE_LUT_PIPE_EN: register after every tree level
// (latency N_IN); otherwise a single output register (latency 1).
module mux_tree_lut #(
    parameter int unsigned          N_IN     = 2,
    parameter int unsigned          LANES    = 4,
    parameter logic [(2**N_IN)-1:0] RESET_TT = 4'b1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    input  logic                    cfg_bit,
    output logic                    cfg_loaded,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic [LANES*N_IN-1:0]   up_data,
    output logic                    down_valid,
    input  logic                    down_ready,
    output logic [LANES-1:0]        down_data
);

    localparam int unsigned       TT_W     = 2**N_IN;
    localparam logic [N_IN-1:0]   CNT_LAST = '1;

    logic [TT_W-1:0] tt;
    logic [TT_W-1:0] shift_in;
    // Bit 0 of a full-width shadow would be shifted out before ever reaching tt,
    // so only the upper TT_W-1 bits are stored; shift_in restores the full word.
    logic [TT_W-2:0] shadow;
    logic [N_IN-1:0] cnt;
    logic            advance;

    // One tree level: output j picks pair (2j, 2j+1) with sel; upper half is zero.
    function automatic logic [TT_W-1:0] tree_level(input logic [TT_W-1:0] v,
                                                   input logic            sel);
        logic [TT_W-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < TT_W/2; j++) begin
            r[j] = sel ? v[2*j+1] : v[2*j];
        end
        return r;
    endfunction

    assign shift_in = {cfg_bit, shadow};
    assign advance  = down_ready || !down_valid;
    assign up_ready = advance;

    // Serial config shift; commit to the active table on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt         <= RESET_TT;
            shadow     <= '0;
            cnt        <= '0;
            cfg_loaded <= 1'b0;
        end else begin
            cfg_loaded <= 1'b0;
            if (cfg_valid) begin
                shadow <= shift_in[TT_W-1:1];
                if (cnt == CNT_LAST) begin
                    tt         <= shift_in;
                    cnt        <= '0;
                    cfg_loaded <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef MUX_TREE_LUT_PIPE_EN
    logic [LANES-1:0][TT_W-1:0] st_data [N_IN];
    logic [LANES-1:0][N_IN-1:0] st_sel  [N_IN];
    logic [N_IN-1:0]            st_valid;

    // One register per tree level; the table is only read at level 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_valid <= '0;
            for (int unsigned s = 0; s < N_IN; s++) begin
                st_data[s] <= '0;
                st_sel[s]  <= '0;
            end
        end else if (advance) begin
            st_valid[0] <= up_valid;
            for (int unsigned i = 0; i < LANES; i++) begin
                st_data[0][i] <= tree_level(tt, up_data[i*N_IN]);
                st_sel[0][i]  <= up_data[i*N_IN +: N_IN] >> 1;
            end
            for (int unsigned s = 1; s < N_IN; s++) begin
                st_valid[s] <= st_valid[s-1];
                for (int unsigned i = 0; i < LANES; i++) begin
                    st_data[s][i] <= tree_level(st_data[s-1][i], st_sel[s-1][i][0]);
                    st_sel[s][i]  <= st_sel[s-1][i] >> 1;
                end
            end
        end
    end

    assign down_valid = st_valid[N_IN-1];

    // Final level leaves each lane's result in bit 0.
    always_comb begin
        down_data = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            down_data[i] = st_data[N_IN-1][i][0];
        end
    end
`else
    logic [LANES-1:0] lut_res;

    function automatic logic lut_eval(input logic [TT_W-1:0] t,
                                      input logic [N_IN-1:0] sel);
        logic [TT_W-1:0] v;
        v = t;
        for (int unsigned k = 0; k < N_IN; k++) begin
            v = tree_level(v, sel[k]);
        end
        return v[0];
    endfunction

    // Full combinational mux tree per lane.
    always_comb begin
        lut_res = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lut_res[i] = lut_eval(tt, up_data[i*N_IN +: N_IN]);
        end
    end

    // Single output register with valid/ready hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            down_valid <= 1'b0;
            down_data  <= '0;
        end else if (advance) begin
            down_valid <= up_valid;
            if (up_valid) begin
                down_data <= lut_res;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux_tree_lut.sv
// Scoreboard bench for mux_tree_lut: instance A (N_IN=2, LANES=4) and
// instance B (N_IN=3, LANES=2). Expected words are queued at acceptance and
// popped by a monitor whenever a DUT output transfers.
module tb_mux_tree_lut;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_cfg_valid, a_cfg_bit, a_cfg_loaded;
    logic       a_up_valid, a_up_ready, a_down_valid, a_down_ready;
    logic [7:0] a_up_data;
    logic [3:0] a_down_data;

    logic       b_cfg_valid, b_cfg_bit, b_cfg_loaded;
    logic       b_up_valid, b_up_ready, b_down_valid, b_down_ready;
    logic [5:0] b_up_data;
    logic [1:0] b_down_data;

    mux_tree_lut #(.N_IN(2), .LANES(4), .RESET_TT(4'b1000)) dut_a (
        .clk(clk), .rst(rst),
        .cfg_valid(a_cfg_valid), .cfg_bit(a_cfg_bit), .cfg_loaded(a_cfg_loaded),
        .up_valid(a_up_valid), .up_ready(a_up_ready), .up_data(a_up_data),
        .down_valid(a_down_valid), .down_ready(a_down_ready), .down_data(a_down_data)
    );

    mux_tree_lut #(.N_IN(3), .LANES(2), .RESET_TT(8'b1000_0000)) dut_b (
        .clk(clk), .rst(rst),
        .cfg_valid(b_cfg_valid), .cfg_bit(b_cfg_bit), .cfg_loaded(b_cfg_loaded),
        .up_valid(b_up_valid), .up_ready(b_up_ready), .up_data(b_up_data),
        .down_valid(b_down_valid), .down_ready(b_down_ready), .down_data(b_down_data)
    );

    int          checks = 0;
    int          errs   = 0;
    logic [3:0]  exp_a[$];
    logic [1:0]  exp_b[$];
    int unsigned cnt_a, cnt_b;
    logic        pend_a, pend_b;
    int          loads_a;
    logic [3:0]  hold_d;
    logic        hold_p;

    // XOR-table stall vectors (lane 3 .. lane 0) with hand-computed results
    localparam logic [7:0] SW [8] = '{8'b00_00_00_00, 8'b11_10_01_00, 8'b01_01_01_01,
                                      8'b10_10_10_10, 8'b11_11_11_11, 8'b00_01_10_11,
                                      8'b01_00_11_10, 8'b00_00_11_01};
    localparam logic [3:0] SE [8] = '{4'b0000, 4'b0110, 4'b1111, 4'b1111,
                                      4'b0000, 4'b0110, 4'b1001, 4'b0001};
    localparam logic [7:0] W = 8'b11_10_01_00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errs++;
        $display("FAIL %s: got timeout/unexpected event, want none", name);
    endtask

    function automatic logic maj(input logic [2:0] x);
        return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
    endfunction

    task automatic cyc_a(input logic cv, input logic cb, input logic uv,
                         input logic [7:0] ud, input logic [3:0] ex, output logic acc);
        a_cfg_valid = cv; a_cfg_bit = cb; a_up_valid = uv; a_up_data = ud;
        @(negedge clk);
        chk("cfg_loaded_a", 32'(a_cfg_loaded), 32'(pend_a));
        if (a_cfg_loaded) loads_a++;
        acc = uv && a_up_ready;
        if (acc) exp_a.push_back(ex);
        pend_a = cv && (cnt_a == 3);
        if (cv) cnt_a = (cnt_a == 3) ? 0 : cnt_a + 1;
        @(posedge clk); #1;
        a_cfg_valid = 1'b0; a_up_valid = 1'b0;
    endtask

    task automatic cyc_b(input logic cv, input logic cb, input logic uv,
                         input logic [5:0] ud, input logic [1:0] ex, output logic acc);
        b_cfg_valid = cv; b_cfg_bit = cb; b_up_valid = uv; b_up_data = ud;
        @(negedge clk);
        chk("cfg_loaded_b", 32'(b_cfg_loaded), 32'(pend_b));
        acc = uv && b_up_ready;
        if (acc) exp_b.push_back(ex);
        pend_b = cv && (cnt_b == 7);
        if (cv) cnt_b = (cnt_b == 7) ? 0 : cnt_b + 1;
        @(posedge clk); #1;
        b_cfg_valid = 1'b0; b_up_valid = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] ud, input logic [3:0] ex);
        logic acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) cyc_a(1'b0, 1'b0, 1'b1, ud, ex, acc);
        if (!acc) fail("send_a_timeout");
    endtask

    task automatic send_b(input logic [5:0] ud, input logic [1:0] ex);
        logic acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) cyc_b(1'b0, 1'b0, 1'b1, ud, ex, acc);
        if (!acc) fail("send_b_timeout");
    endtask

    task automatic load_a(input logic [3:0] bits);
        logic acc;
        for (int i = 0; i < 4; i++) cyc_a(1'b1, bits[i], 1'b0, 8'h00, 4'h0, acc);
    endtask

    task automatic load_b(input logic [7:0] bits);
        logic acc;
        for (int i = 0; i < 8; i++) cyc_b(1'b1, bits[i], 1'b0, 6'h00, 2'h0, acc);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_a_empty", 32'(exp_a.size()), 0);
        chk("drain_b_empty", 32'(exp_b.size()), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_cfg_valid = 1'b0; a_cfg_bit = 1'b0; a_up_valid = 1'b0; a_up_data = '0;
        b_cfg_valid = 1'b0; b_cfg_bit = 1'b0; b_up_valid = 1'b0; b_up_data = '0;
        a_down_ready = 1'b1; b_down_ready = 1'b1;
        #2;
        chk("rst_down_valid_a", 32'(a_down_valid), 0);
        chk("rst_down_data_a", 32'(a_down_data), 0);
        chk("rst_cfg_loaded_a", 32'(a_cfg_loaded), 0);
        chk("rst_up_ready_a", 32'(a_up_ready), 1);
        chk("rst_down_valid_b", 32'(b_down_valid), 0);
        exp_a.delete(); exp_b.delete();
        cnt_a = 0; cnt_b = 0; pend_a = 1'b0; pend_b = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic monitor();
        logic [3:0] e;
        logic [1:0] eb;
        hold_p = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_p = 1'b0;
            end else begin
                if (hold_p) begin
                    chk("hold_valid_a", 32'(a_down_valid), 1);
                    chk("hold_data_a", 32'(a_down_data), 32'(hold_d));
                end
                hold_p = a_down_valid && !a_down_ready;
                hold_d = a_down_data;
                if (a_down_valid && a_down_ready) begin
                    if (exp_a.size() == 0) fail("extra_word_a");
                    else begin
                        e = exp_a.pop_front();
                        chk("data_a", 32'(a_down_data), 32'(e));
                    end
                end
                if (b_down_valid && b_down_ready) begin
                    if (exp_b.size() == 0) fail("extra_word_b");
                    else begin
                        eb = exp_b.pop_front();
                        chk("data_b", 32'(b_down_data), 32'(eb));
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        logic acc;
        int   l0;
        int   c;
        int   w;
        loads_a = 0;
        do_reset();

        // Reset table is AND
        send_a(W, 4'b1000);
        drain();

        // Load XOR; pulse in 5th cycle, table already usable there
        l0 = loads_a;
        load_a(4'b0110);
        cyc_a(1'b0, 1'b0, 1'b1, W, 4'b0110, acc);
        chk("xor_word_accepted", 32'(acc), 1);
        chk("xor_load_pulses", 32'(loads_a - l0), 1);
        drain();

        // Stall for 5 cycles with 8 pending words
        c = 0; w = 0;
        while (w < 8 && c < 40) begin
            a_down_ready = (c >= 5);
            cyc_a(1'b0, 1'b0, 1'b1, SW[w], SE[w], acc);
            if (c == 3 || c == 4) chk("up_ready_stall", 32'(acc), 0);
            if (acc) w++;
            c++;
        end
        if (w < 8) fail("stall_timeout");
        a_down_ready = 1'b1;
        drain();

        // Last config bit (OR table 1110) alongside an accepted word
        cyc_a(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, acc);
        cyc_a(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, acc);
        cyc_a(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, acc);
        cyc_a(1'b1, 1'b1, 1'b1, W, 4'b0110, acc);
        chk("commit_cycle_accept", 32'(acc), 1);
        cyc_a(1'b0, 1'b0, 1'b1, W, 4'b1110, acc);
        chk("post_commit_accept", 32'(acc), 1);
        drain();

        // Partial load plus in-flight word, then reset
        cyc_a(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, acc);
        cyc_a(1'b1, 1'b1, 1'b1, W, 4'b1110, acc);
        do_reset();
        send_a(W, 4'b1000);
        l0 = loads_a;
        load_a(4'b0110);
        cyc_a(1'b0, 1'b0, 1'b1, W, 4'b0110, acc);
        cyc_a(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, acc);
        chk("reload_pulses", 32'(loads_a - l0), 1);
        drain();

        // Majority on the 3-input instance, full sweep
        load_b(8'b1110_1000);
        for (int v = 0; v < 64; v++) begin
            logic [5:0] d;
            d = 6'(v);
            send_b(d, {maj(d[5:3]), maj(d[2:0])});
        end
        drain();
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                #200000;
                fail("global_timeout");
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mux_tree_lut.md
# mux_tree_lut

- Multi-lane lookup cell that generalises mux-based gate construction.
- Each lane evaluates an arbitrary N_IN-input boolean function using a binary tree of 2:1 muxes. The leaves of the tree are the bits of a truth table, and the select lines are the lane inputs.
- The truth table is loaded at run time over a serial config port through a shadow register.
- Data moves through a valid/ready stream stage. The block sits between combinational test fabrics and stream consumers that need a reprogrammable gate.

## Interface
Parameters:
- N_IN, 2, inputs per lane (tree depth), 1..6
- LANES, 4, parallel lanes sharing one truth table
- RESET_TT, 4'b1000, active truth table after reset, width 2**N_IN (default = AND)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- cfg_valid  input  1  a config bit is presented this cycle
- cfg_bit  input  1  serial truth-table bit, table index 0 first
- cfg_loaded  output  1  one-cycle pulse: new table committed
- up_valid  input  1  input word valid
- up_ready  output  1  block accepts input word
- up_data  input  LANES*N_IN  lane i inputs at [i*N_IN +: N_IN], bit 0 = tree level 0 select
- down_valid  output  1  output word valid
- down_ready  input  1  consumer accepts output word
- down_data  output  LANES  lane i result at bit i

## Operation
- Active table tt[2**N_IN-1:0]. Lane result = tt[lane_inputs] (lane inputs read as an unsigned index), built as a mux tree.
- Tree level k selects between pairs using input bit k. Level 0 chooses tt[2j] (bit 0 = 0) or tt[2j+1] (bit 0 = 1).
- Config loading:
  - Each cycle cfg_valid=1 shifts the bit into the shadow register: shadow <= {cfg_bit, shadow[MSB:1]}. A cnt register increments.
  - When cnt reaches 2**N_IN-1 with cfg_valid=1, the next edge does three things: commits {cfg_bit, shadow[MSB:1]} to tt, clears cnt, and asserts cfg_loaded for one cycle.
  - A partially shifted shadow never affects tt.
- The table is read only at tree level 0, i.e. at the input acceptance stage. A word accepted in the same cycle as a commit uses the old table. A word accepted one cycle after the commit uses the new table.
- Stream handshake:
  - A transfer occurs when valid && ready.
  - The whole pipeline advances when down_ready || !down_valid. up_ready equals that condition.
  - down_data and down_valid are held stable while down_valid && !down_ready.
- Reset values: tt=RESET_TT, shadow=0, cnt=0, cfg_loaded=0, down_valid=0, down_data=0, all stage valids=0.
- Reset mid-load: partial shadow and cnt are discarded. Reset mid-stream: in-flight words are dropped.
- cfg_valid and stream traffic are independent. Both may be active in the same cycle.

## Timing
- Without pipelining: latency 1. A word accepted at edge t shows down_valid=1 after edge t. Throughput is 1 word/cycle when down_ready=1.
- With pipelining: latency N_IN cycles (one register per tree level). Throughput is 1 word/cycle. Under stall, all stages hold.
- Commit: cfg_loaded is high in the cycle following the edge that captured the last config bit. tt is valid from that same cycle.
- Back-to-back table loads: no gap is required. Bit 0 of the next table may arrive in the cycle after the last bit of the previous one.

## Configuration
- Macro MUX_TREE_LUT_PIPE_EN.
- Defined: each tree level is followed by a register stage that carries the partial results, the remaining select bits and a stage valid. Latency is N_IN.
- Undefined: the tree is fully combinational from up_data and tt, with a single output register. Latency is 1.
- Both builds have identical handshake semantics and identical results.

## Test plan
- After reset, N_IN=2, LANES=4: drive up_data=8'b11_10_01_00 (lane 3 down to lane 0). Require down_data=4'b1000 (AND per lane) after the build latency.
- Load table 0110 by shifting cfg_bit 0,1,1,0 on four consecutive cycles. Require a cfg_loaded pulse on the 5th cycle. Resend the same word; require down_data=4'b0110 (XOR).
- Hold down_ready=0 for 5 cycles while up_valid=1. Require up_ready=0, a stable down_data and no lost or duplicated words. Release the stall and check the sequence of 8 words in order.
- Send the last config bit in the same cycle a word is accepted. Require that word to use the old table, and the next word to use the new table.
- Shift in 2 of 4 config bits, then pulse rst. Require tt=RESET_TT, cnt=0, down_valid=0. Then send a full 4-bit load and require exactly one cfg_loaded.
- N_IN=3, LANES=2, load table 8'b1110_1000 (majority). Sweep all 64 input pairs and require the result to match majority for both lanes, in both the MUX_TREE_LUT_PIPE_EN and non-pipelined builds.
